// File: rtl/serial_add_sub_if.sv
// Operand/result bundle for the bit-serial adder/subtractor.
// master drives the request side; slave is the arithmetic unit.
interface serial_add_sub_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, op_sub, a_in, b_in,
    input  busy, done, result, c_out, ovf
  );

  modport slave (
    input  start, op_sub, a_in, b_in,
    output busy, done, result, c_out, ovf
  );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one operand bit pair per clock, LSB first,
// through a single full-adder/full-subtractor cell and a carry/borrow flip-flop.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_sub_if.slave  bus_io
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_a_q, shift_a_d;
  logic [WIDTH-1:0] shift_b_q, shift_b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             op_q, op_d;
  logic             cbit_q, cbit_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic             a0, b0, s_bit, carry_nxt, last_bit, ovf_nxt;
  logic [WIDTH-1:0] acc_shifted;

  // One-bit add/subtract cell plus the accumulator value after this bit lands.
  always_comb begin
    a0        = shift_a_q[0];
    b0        = shift_b_q[0];
    s_bit     = a0 ^ b0 ^ cbit_q;
    carry_nxt = op_q ? ((~a0 & b0) | (~(a0 ^ b0) & cbit_q))
                     : ((a0 & b0) | ((a0 ^ b0) & cbit_q));
    // Written as shift-then-set so WIDTH=1 needs no empty slice.
    acc_shifted            = acc_q >> 1;
    acc_shifted[WIDTH-1]   = s_bit;
    last_bit  = (cnt_q == CntW'(WIDTH - 1));
    // On the last bit s_bit is the result MSB.
    ovf_nxt   = op_q ? ((a_msb_q != b_msb_q) & (s_bit != a_msb_q))
                     : ((a_msb_q == b_msb_q) & (s_bit != a_msb_q));
  end

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d   = state_q;
    shift_a_d = shift_a_q;
    shift_b_d = shift_b_q;
    acc_d     = acc_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    cbit_d    = cbit_q;
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    c_out_d   = c_out_q;
    ovf_d     = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus_io.start) begin
          state_d   = StRun;
          shift_a_d = bus_io.a_in;
          shift_b_d = bus_io.b_in;
          op_d      = bus_io.op_sub;
          cbit_d    = 1'b0;
          cnt_d     = '0;
          acc_d     = '0;
          a_msb_d   = bus_io.a_in[WIDTH-1];
          b_msb_d   = bus_io.b_in[WIDTH-1];
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        shift_a_d = shift_a_q >> 1;
        shift_b_d = shift_b_q >> 1;
        acc_d     = acc_shifted;
        cbit_d    = carry_nxt;
        cnt_d     = cnt_q + CntW'(1);
        if (last_bit) begin
          state_d  = StDone;
          result_d = acc_shifted;
          c_out_d  = carry_nxt;
          ovf_d    = ovf_nxt;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_a_q <= '0;
      shift_b_q <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      cbit_q    <= 1'b0;
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
      c_out_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_a_q <= shift_a_d;
      shift_b_q <= shift_b_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      cbit_q    <= cbit_d;
      a_msb_q   <= a_msb_d;
      b_msb_q   <= b_msb_d;
      c_out_q   <= c_out_d;
      ovf_q     <= ovf_d;
    end
  end

  // Status and results straight from registers.
  always_comb begin
    bus_io.busy   = (state_q == StRun);
    bus_io.done   = (state_q == StDone);
    bus_io.result = result_q;
    bus_io.c_out  = c_out_q;
    bus_io.ovf    = ovf_q;
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: WIDTH=8 and WIDTH=1 instances, arithmetic reference model.
module tb_serial_add_sub;

  typedef struct {
    logic [7:0] result;
    logic       c_out;
    logic       ovf;
    int         edge_no;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   edge_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t q8[$];
  exp_t q1[$];
  int   next_acc8 = 0;
  int   next_acc1 = 0;
  int   last_k8 = -100;

  serial_add_sub_if #(.WIDTH(8)) bus8 ();
  serial_add_sub_if #(.WIDTH(1)) bus1 ();

  serial_add_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus_io(bus8));
  serial_add_sub #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus_io(bus1));

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic exp_t ref_model(int unsigned w, int unsigned a, int unsigned b, bit sub);
    exp_t        r;
    int unsigned m;
    int          sa, sb, sr;
    m        = 32'd1 << w;
    r.result = 8'(sub ? (a + m - b) % m : (a + b) % m);
    r.c_out  = sub ? (a < b) : ((a + b) >= m);
    sa       = (a >= m / 2) ? int'(a) - int'(m) : int'(a);
    sb       = (b >= m / 2) ? int'(b) - int'(m) : int'(b);
    sr       = sub ? sa - sb : sa + sb;
    r.ovf    = (sr > int'(m / 2) - 1) || (sr < -int'(m / 2));
    r.edge_no = 0;
    return r;
  endfunction

  // One cycle of stimulus to the 8-bit unit; the model decides whether start is taken.
  task automatic drive8(bit st, logic [7:0] a, logic [7:0] b, bit sub);
    exp_t e;
    @(negedge clk);
    bus8.start  = st;
    bus8.a_in   = a;
    bus8.b_in   = b;
    bus8.op_sub = sub;
    if (st && !rst && (edge_cnt + 1) >= next_acc8) begin
      e         = ref_model(8, a, b, sub);
      e.edge_no = edge_cnt + 1 + 8;
      q8.push_back(e);
      last_k8   = edge_cnt + 1;
      next_acc8 = edge_cnt + 1 + 9;
    end
  endtask

  task automatic drive1(bit st, logic a, logic b, bit sub);
    exp_t e;
    @(negedge clk);
    bus1.start  = st;
    bus1.a_in   = a;
    bus1.b_in   = b;
    bus1.op_sub = sub;
    if (st && !rst && (edge_cnt + 1) >= next_acc1) begin
      e         = ref_model(1, {31'd0, a}, {31'd0, b}, sub);
      e.edge_no = edge_cnt + 1 + 1;
      q1.push_back(e);
      next_acc1 = edge_cnt + 1 + 2;
    end
  endtask

  task automatic idle8(int n);
    for (int i = 0; i < n; i++) drive8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
  endtask

  task automatic check_bit(string name, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, got, exp, $time);
    end
  endtask

  // Monitor for the 8-bit unit: busy window every cycle, results when done pulses.
  always @(negedge clk) begin
    exp_t e;
    logic exp_busy;
    if (!rst) begin
      exp_busy = (edge_cnt >= last_k8) && (edge_cnt < last_k8 + 8);
      checks++;
      if (bus8.busy !== exp_busy) begin
        errors++;
        $display("FAIL busy8: got %b expected %b at edge %0d", bus8.busy, exp_busy, edge_cnt);
      end
      if (bus8.done === 1'b1) begin
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL done8_unexpected: got done=1 expected done=0 at edge %0d", edge_cnt);
        end else begin
          e = q8.pop_front();
          if (bus8.result !== e.result || bus8.c_out !== e.c_out || bus8.ovf !== e.ovf ||
              edge_cnt != e.edge_no) begin
            errors++;
            $display("FAIL result8: got r=%h c=%b v=%b edge=%0d expected r=%h c=%b v=%b edge=%0d",
                     bus8.result, bus8.c_out, bus8.ovf, edge_cnt,
                     e.result, e.c_out, e.ovf, e.edge_no);
          end
        end
      end else if (q8.size() > 0 && edge_cnt >= q8[0].edge_no) begin
        checks++;
        errors++;
        $display("FAIL done8_missing: got done=0 expected done=1 at edge %0d", q8[0].edge_no);
        void'(q8.pop_front());
      end
    end
  end

  // Monitor for the 1-bit unit.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus1.done === 1'b1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL done1_unexpected: got done=1 expected done=0 at edge %0d", edge_cnt);
        end else begin
          e = q1.pop_front();
          if (bus1.result !== e.result[0] || bus1.c_out !== e.c_out || bus1.ovf !== e.ovf ||
              edge_cnt != e.edge_no) begin
            errors++;
            $display("FAIL result1: got r=%b c=%b v=%b edge=%0d expected r=%b c=%b v=%b edge=%0d",
                     bus1.result, bus1.c_out, bus1.ovf, edge_cnt,
                     e.result[0], e.c_out, e.ovf, e.edge_no);
          end
        end
      end else if (q1.size() > 0 && edge_cnt >= q1[0].edge_no) begin
        checks++;
        errors++;
        $display("FAIL done1_missing: got done=0 expected done=1 at edge %0d", q1[0].edge_no);
        void'(q1.pop_front());
      end
    end
  end

  initial begin
    bus8.start = 1'b0; bus8.op_sub = 1'b0; bus8.a_in = '0; bus8.b_in = '0;
    bus1.start = 1'b0; bus1.op_sub = 1'b0; bus1.a_in = '0; bus1.b_in = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check_bit("rst_busy", bus8.busy, 1'b0);
    check_bit("rst_done", bus8.done, 1'b0);
    check_bit("rst_result_zero", bus8.result == 8'h00, 1'b1);
    check_bit("rst_c_out", bus8.c_out, 1'b0);
    check_bit("rst_ovf", bus8.ovf, 1'b0);
    rst = 1'b0;

    // Directed add/sub cases.
    drive8(1'b1, 8'h35, 8'h4A, 1'b0); idle8(8);
    drive8(1'b1, 8'hFF, 8'h01, 1'b0); idle8(8);
    drive8(1'b1, 8'h7F, 8'h01, 1'b0); idle8(8);
    drive8(1'b1, 8'h05, 8'h07, 1'b1); idle8(8);
    drive8(1'b1, 8'h80, 8'h01, 1'b1); idle8(10);

    // start held every cycle with changing operands: only boundary starts are taken.
    drive8(1'b1, 8'h12, 8'h34, 1'b0);
    for (int i = 0; i < 30; i++) drive8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom));
    idle8(12);

    // Random traffic; early starts must be ignored.
    for (int i = 0; i < 400; i++)
      drive8($urandom_range(0, 3) == 0, 8'($urandom), 8'($urandom), 1'($urandom));
    idle8(12);

    // Non-zero result on the outputs before the abort.
    drive8(1'b1, 8'hC3, 8'h11, 1'b0); idle8(10);

    // Asynchronous reset in the fourth RUN cycle.
    drive8(1'b1, 8'hA5, 8'h3C, 1'b0);
    @(posedge clk);
    #1 bus8.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    q8.delete();
    last_k8   = -100;
    next_acc8 = 0;
    #1;
    check_bit("abort_busy", bus8.busy, 1'b0);
    check_bit("abort_done", bus8.done, 1'b0);
    check_bit("abort_result_zero", bus8.result == 8'h00, 1'b1);
    check_bit("abort_c_out", bus8.c_out, 1'b0);
    check_bit("abort_ovf", bus8.ovf, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    drive8(1'b1, 8'h10, 8'h20, 1'b0); idle8(10);

    // WIDTH=1 truth tables.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      drive1(1'b1, v[0], v[1], v[2]);
      drive1(1'b0, 1'b0, 1'b0, 1'b0);
    end
    // Back-to-back on the 1-bit unit.
    for (int i = 0; i < 12; i++) drive1(1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 4; i++) drive1(1'b0, 1'b0, 1'b0, 1'b0);
    idle8(2);

    checks++;
    if (q8.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending expected 0/0", q8.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
